// File: rtl/encode_8b10b_lanes.sv
// Multi-lane 8b/10b encoder: LANES bytes per clock, running disparity chained lane 0 -> LANES-1.
// Optional idle fill (K28.5 words whenever the output slot is free) under ENC8B10B_IDLE_FILL_EN.
module encode_8b10b_lanes #(
  parameter int unsigned LANES = 2,
  parameter logic [7:0]  SUB_K = 8'hBC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [LANES-1:0]      in_k,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_k_err,
  output logic                  rd
);

  logic                r_out_valid;
  logic [10*LANES-1:0] r_out_data;
  logic [LANES-1:0]    r_out_k_err;
  logic                r_rd;

  logic                w_load;
  logic                w_idle;
  logic [10*LANES-1:0] w_code;
  logic [LANES-1:0]    w_err;
  logic                w_rd_next;

  function automatic logic f_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) ||
           ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                 (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction

  // abcdei codes as seen from RD-
  function automatic logic [5:0] f_6b_neg(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;
      5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;
      5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;
      5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;
      5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;
      5'd9:  return 6'b100101;
      5'd10: return 6'b010101;
      5'd11: return 6'b110100;
      5'd12: return 6'b001101;
      5'd13: return 6'b101100;
      5'd14: return 6'b011100;
      5'd15: return 6'b010111;
      5'd16: return 6'b011011;
      5'd17: return 6'b100011;
      5'd18: return 6'b010011;
      5'd19: return 6'b110010;
      5'd20: return 6'b001011;
      5'd21: return 6'b101010;
      5'd22: return 6'b011010;
      5'd23: return 6'b111010;
      5'd24: return 6'b110011;
      5'd25: return 6'b100110;
      5'd26: return 6'b010110;
      5'd27: return 6'b110110;
      5'd28: return 6'b001110;
      5'd29: return 6'b101110;
      5'd30: return 6'b011110;
      default: return 6'b101011;
    endcase
  endfunction

  // fghj codes as seen from RD- (the RD left after the 6b sub-block)
  function automatic logic [3:0] f_4b_neg(input logic [2:0] y, input logic k, input logic alt);
    if (k) begin
      case (y)
        3'd0: return 4'b1011;
        3'd1: return 4'b0110;
        3'd2: return 4'b1010;
        3'd3: return 4'b1100;
        3'd4: return 4'b1101;
        3'd5: return 4'b0101;
        3'd6: return 4'b1001;
        default: return 4'b0111;
      endcase
    end
    case (y)
      3'd0: return 4'b1011;
      3'd1: return 4'b1001;
      3'd2: return 4'b0101;
      3'd3: return 4'b1100;
      3'd4: return 4'b1101;
      3'd5: return 4'b1010;
      3'd6: return 4'b0110;
      default: return alt ? 4'b0111 : 4'b1110;
    endcase
  endfunction

  // Returns {ending RD, abcdei fghj}
  function automatic logic [10:0] f_enc(input logic [7:0] b, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       rd6;
    logic       alt;
    logic       rd_out;
    x  = b[4:0];
    y  = b[7:5];
    s6 = (k && (x == 5'd28)) ? 6'b001111 : f_6b_neg(x);
    if (rd_in && (($countones(s6) != 3) || (x == 5'd7))) s6 = ~s6;
    rd6 = ($countones(s6) == 3) ? rd_in : ($countones(s6) > 3);
    alt = !k && (y == 3'd7) &&
          (rd_in ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                 : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)));
    s4 = f_4b_neg(y, k, alt);
    if (rd6 && (k || ($countones(s4) != 2) || (y == 3'd3))) s4 = ~s4;
    rd_out = ($countones(s4) == 2) ? rd6 : ($countones(s4) > 2);
    return {rd_out, s6, s4};
  endfunction

  assign in_ready = !r_out_valid || out_ready;

`ifdef ENC8B10B_IDLE_FILL_EN
  assign w_load = in_ready;
  assign w_idle = !in_valid;
`else
  assign w_load = in_valid && in_ready;
  assign w_idle = 1'b0;
`endif

  always_comb begin
    logic       rd_v;
    logic [7:0] b;
    logic       k;
    logic       err;
    logic [10:0] enc;
    rd_v   = r_rd;
    w_code = '0;
    w_err  = '0;
    for (int i = 0; i < LANES; i++) begin
      b        = w_idle ? 8'hBC : in_data[8*i +: 8];
      k        = w_idle | in_k[i];
      err      = k && !f_legal_k(b);
      enc      = f_enc(err ? SUB_K : b, k, rd_v);
      w_err[i] = err;
      w_code[10*i +: 10] = enc[9:0];
      rd_v     = enc[10];
    end
    w_rd_next = rd_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_k_err <= '0;
      r_rd        <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_code;
      r_out_k_err <= w_err;
      r_rd        <= w_rd_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_k_err = r_out_k_err;
  assign rd        = r_rd;

endmodule

// File: tb/tb_encode_8b10b_lanes.sv
// Bench for encode_8b10b_lanes: randomized LANES=2 stream against a table-driven model,
// plus literal checks on a LANES=1 instance.
module tb_encode_8b10b_lanes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LANES=2 instance (model-checked)
  logic        v2 = 1'b0, ordy2 = 1'b1, irdy2, ov2, rd2;
  logic [15:0] d2 = '0;
  logic [1:0]  k2 = '0, e2;
  logic [19:0] od2;

  // LANES=1 instance (literal checks)
  logic        v1 = 1'b0, ordy1 = 1'b1, irdy1, ov1, rd1;
  logic [7:0]  d1 = '0;
  logic [0:0]  k1 = '0, e1;
  logic [9:0]  od1;

  encode_8b10b_lanes #(.LANES(2), .SUB_K(8'hBC)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(irdy2), .in_data(d2), .in_k(k2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_k_err(e2), .rd(rd2)
  );

  encode_8b10b_lanes #(.LANES(1), .SUB_K(8'hBC)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(irdy1), .in_data(d1), .in_k(k1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_k_err(e1), .rd(rd1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
  endtask

  // Standard code tables; RD+ columns derived by the complement rule or listed directly.
  logic [5:0] t6n [32];
  logic [5:0] t6p [32];
  logic [3:0] t4n [8];
  logic [3:0] t4p [8];
  logic [3:0] tk4n [8];
  logic [3:0] tk4p [8];

  initial begin
    t6n = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001,
            6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
            6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011,
            6'b101010, 6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110,
            6'b001110, 6'b101110, 6'b011110, 6'b101011};
    for (int i = 0; i < 32; i++)
      t6p[i] = (($countones(t6n[i]) == 3) && (i != 7)) ? t6n[i] : ~t6n[i];
    t4n  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    t4p  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    tk4n = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    tk4p = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  end

  // {k_err, ending RD, 10b symbol}
  function automatic logic [11:0] m_sym(input logic [7:0] b_in, input logic k, input logic rdi);
    logic [7:0] b;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       r, err, a7, legal;
    int         d;
    legal = (b_in[4:0] == 5'd28) || ((b_in[7:5] == 3'd7) &&
            (b_in[4:0] == 5'd23 || b_in[4:0] == 5'd27 || b_in[4:0] == 5'd29 ||
             b_in[4:0] == 5'd30));
    err = k && !legal;
    b   = err ? 8'hBC : b_in;
    x   = b[4:0];
    y   = b[7:5];
    if (k && x == 5'd28) s6 = rdi ? 6'b110000 : 6'b001111;
    else s6 = rdi ? t6p[x] : t6n[x];
    d = 2 * $countones(s6) - 6;
    r = (d > 0) ? 1'b1 : (d < 0) ? 1'b0 : rdi;
    if (k) s4 = r ? tk4p[y] : tk4n[y];
    else if (y == 3'd7) begin
      a7 = rdi ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
               : (x == 5'd17 || x == 5'd18 || x == 5'd20);
      s4 = a7 ? (r ? 4'b1000 : 4'b0111) : (r ? 4'b0001 : 4'b1110);
    end else s4 = r ? t4p[y] : t4n[y];
    d = 2 * $countones(s4) - 4;
    r = (d > 0) ? 1'b1 : (d < 0) ? 1'b0 : r;
    return {err, r, s6, s4};
  endfunction

  // Cycle model of the LANES=2 instance
  logic        m_valid, m_rd, m_load, m_idle, m_rdv;
  logic [19:0] m_data;
  logic [1:0]  m_err;
  logic [11:0] m_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_err   = '0;
      m_rd    = 1'b0;
    end else begin
`ifdef ENC8B10B_IDLE_FILL_EN
      m_load = !m_valid || ordy2;
      m_idle = !v2;
`else
      m_load = v2 && (!m_valid || ordy2);
      m_idle = 1'b0;
`endif
      if (m_load) begin
        m_rdv = m_rd;
        for (int i = 0; i < 2; i++) begin
          m_s = m_idle ? m_sym(8'hBC, 1'b1, m_rdv) : m_sym(d2[8*i +: 8], k2[i], m_rdv);
          m_data[10*i +: 10] = m_s[9:0];
          m_err[i] = m_s[11];
          m_rdv = m_s[10];
        end
        m_rd    = m_rdv;
        m_valid = 1'b1;
      end else if (ordy2) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("l2_out_valid", ov2, m_valid);
      chk("l2_in_ready", irdy2, !m_valid || ordy2);
      chk("l2_rd", rd2, m_rd);
      chk("l2_out_data", od2, m_data);
      chk("l2_out_k_err", e2, m_err);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    #12;
    // reset state and model pins
    chk("rst_valid1", ov1, 1'b0);
    chk("rst_data1", od1, 10'd0);
    chk("rst_rd1", rd1, 1'b0);
    chk("rst_valid2", ov2, 1'b0);
    chk("rst_data2", od2, 20'd0);
    chk("rst_err2", e2, 2'b00);
    chk("model_d000", m_sym(8'h00, 1'b0, 1'b0), {2'b00, 10'b1001110100});
    chk("model_k285p", m_sym(8'hBC, 1'b1, 1'b1), {2'b00, 10'b1100000101});
    chk("model_d177", m_sym(8'hF1, 1'b0, 1'b0), {2'b01, 10'b1000110111});
    chk("model_d117p", m_sym(8'hEB, 1'b0, 1'b1), {2'b00, 10'b1101001000});
    chk("model_badk", m_sym(8'h00, 1'b1, 1'b0), {2'b11, 10'b0011111010});

    step();
    rst = 1'b0;
    v1 = 1'b1; d1 = 8'h00; k1 = 1'b0;
    v2 = 1'b1; d2 = 16'hBCBC; k2 = 2'b11;
    step();
    chk("d000_data", od1, 10'b1001110100);
    chk("d000_rd", rd1, 1'b0);
    chk("k285x2_data", od2, {10'b1100000101, 10'b0011111010});
    chk("k285x2_rd", rd2, 1'b0);
    d1 = 8'hF1;
    d2 = 16'h0000; k2 = 2'b01;
    step();
    chk("d177_data", od1, 10'b1000110111);
    chk("d177_rd", rd1, 1'b1);
    chk("badk_data", od2, {10'b0110001011, 10'b0011111010});
    chk("badk_err", e2, 2'b01);
    chk("badk_rd", rd2, 1'b1);
    d1 = 8'hEB;
    v2 = 1'b0; k2 = 2'b00;
    step();
    chk("d117_data", od1, 10'b1101001000);
    chk("d117_rd", rd1, 1'b0);

    // stall with a pending word, then release
    d1 = 8'hF1;
    step();
    ordy1 = 1'b0; d1 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", irdy1, 1'b0);
      chk("stall_valid", ov1, 1'b1);
      chk("stall_data", od1, 10'b1000110111);
      chk("stall_rd", rd1, 1'b1);
    end
    ordy1 = 1'b1;
    step();
    chk("release_data", od1, 10'b0110001011);
    chk("release_rd", rd1, 1'b1);
    chk("release_valid", ov1, 1'b1);

    // asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    chk("arst_valid", ov1, 1'b0);
    chk("arst_data", od1, 10'd0);
    chk("arst_rd", rd1, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_data", od1, 10'b1001110100);
    chk("post_rst_rd", rd1, 1'b0);
    v1 = 1'b0;
`ifdef ENC8B10B_IDLE_FILL_EN
    step();
    chk("idle0", od1, 10'b0011111010);
    step();
    chk("idle1", od1, 10'b1100000101);
    chk("idle_valid", ov1, 1'b1);
`endif

    // randomized stream on the two-lane instance
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n == 1500) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      v2    = ($urandom_range(0, 3) != 0);
      ordy2 = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 2; i++) begin
        d2[8*i +: 8] = 8'($urandom);
        k2[i] = ($urandom_range(0, 4) == 0);
        if (k2[i]) begin
          r = $urandom_range(0, 15);
          if (r < 8) d2[8*i +: 8] = {3'(r), 5'd28};
          else if (r == 8) d2[8*i +: 8] = {3'd7, 5'd23};
          else if (r == 9) d2[8*i +: 8] = {3'd7, 5'd27};
          else if (r == 10) d2[8*i +: 8] = {3'd7, 5'd29};
          else if (r == 11) d2[8*i +: 8] = {3'd7, 5'd30};
        end
      end
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
